// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
// configurable memory wait states, jal/lui support and an illegal-opcode trap.
module mc_ctrl #(
    parameter int MEM_LAT   = 0,
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RFWr,
    output logic       DMWr,
    output logic [1:0] EXTOp,
    output logic [1:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic       BSel,
    output logic [1:0] A3Sel,
    output logic [1:0] WDSel,
    output logic       retire,
    output logic       err
);

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;

    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALUWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_JUMP,
        S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    logic       cnt_last;

    logic       pcwr_c, irwr_c, rfwr_c, dmwr_c, bsel_c, retire_c, err_c;
    logic [1:0] extop_c, aluop_c, npcop_c, a3sel_c, wdsel_c;
    logic [1:0] alu_ext_c, alu_op_c;
    logic       alu_bsel_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= 3'd0;
            op_q    <= 6'd0;
            funct_q <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    assign cnt_last = (cnt_q == LAST_CNT);

    // Next state, wait counter and opcode capture
    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            S_FETCH: if (cnt_last) state_d = S_DECODE;
            S_DECODE: begin
                op_d    = Op;
                funct_d = Funct;
                case (Op)
                    OP_R:           state_d = (Funct == F_ADDU || Funct == F_SUBU) ? S_EXEC : S_TRAP;
                    OP_ORI, OP_LUI: state_d = S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (cnt_last) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (cnt_last) state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = TRAP_HALT ? S_TRAP : S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        // Counter only advances inside memory access states; it is 0 on exit.
        if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !cnt_last)
            cnt_d = cnt_q + 3'd1;
    end

    // ALU/extender controls shared by EXEC and ALUWB
    always_comb begin
        alu_op_c   = 2'b00;
        alu_ext_c  = 2'b00;
        alu_bsel_c = 1'b0;
        case (op_q)
            OP_R:   alu_op_c = (funct_q == F_SUBU) ? 2'b01 : 2'b00;
            OP_ORI: begin
                alu_op_c   = 2'b10;
                alu_bsel_c = 1'b1;
            end
            OP_LUI: begin
                alu_op_c   = 2'b10;
                alu_bsel_c = 1'b1;
                alu_ext_c  = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        pcwr_c   = 1'b0;
        irwr_c   = 1'b0;
        rfwr_c   = 1'b0;
        dmwr_c   = 1'b0;
        extop_c  = 2'b00;
        aluop_c  = 2'b00;
        npcop_c  = 2'b00;
        bsel_c   = 1'b0;
        a3sel_c  = 2'b00;
        wdsel_c  = 2'b00;
        retire_c = 1'b0;
        err_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwr_c = cnt_last;
                pcwr_c = cnt_last;
            end
            S_EXEC: begin
                aluop_c = alu_op_c;
                extop_c = alu_ext_c;
                bsel_c  = alu_bsel_c;
            end
            S_ALUWB: begin
                aluop_c  = alu_op_c;
                extop_c  = alu_ext_c;
                bsel_c   = alu_bsel_c;
                rfwr_c   = 1'b1;
                a3sel_c  = (op_q == OP_R) ? 2'b01 : 2'b00;
                retire_c = 1'b1;
            end
            S_MEMADR: begin
                bsel_c  = 1'b1;
                extop_c = 2'b01;
            end
            S_MEMWB: begin
                rfwr_c   = 1'b1;
                wdsel_c  = 2'b01;
                retire_c = 1'b1;
            end
            S_MEMWR: begin
                dmwr_c   = cnt_last;
                retire_c = cnt_last;
            end
            S_BRANCH: begin
                aluop_c  = 2'b01;
                extop_c  = 2'b01;
                npcop_c  = 2'b01;
                pcwr_c   = Zero;
                retire_c = 1'b1;
            end
            S_JUMP: begin
                npcop_c  = 2'b10;
                pcwr_c   = 1'b1;
                retire_c = 1'b1;
                // jal links the PC that FETCH already advanced
                if (op_q == OP_JAL) begin
                    rfwr_c  = 1'b1;
                    a3sel_c = 2'b10;
                    wdsel_c = 2'b10;
                end
            end
            S_TRAP: err_c = 1'b1;
            default: ;
        endcase
    end

    // Outputs are forced low for as long as reset is held.
    assign PCWr   = rst & pcwr_c;
    assign IRWr   = rst & irwr_c;
    assign RFWr   = rst & rfwr_c;
    assign DMWr   = rst & dmwr_c;
    assign EXTOp  = rst ? extop_c : 2'b00;
    assign ALUOp  = rst ? aluop_c : 2'b00;
    assign NPCOp  = rst ? npcop_c : 2'b00;
    assign BSel   = rst & bsel_c;
    assign A3Sel  = rst ? a3sel_c : 2'b00;
    assign WDSel  = rst ? wdsel_c : 2'b00;
    assign retire = rst & retire_c;
    assign err    = rst & err_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: three configurations run the same instruction repeatedly
// after each reset and every cycle is compared with a phase-based timing model.
module tb_mc_ctrl;

    localparam int NI = 3;

    logic       clk;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;

    logic       pcwr_w [NI];
    logic       irwr_w [NI];
    logic       rfwr_w [NI];
    logic       dmwr_w [NI];
    logic [1:0] extop_w [NI];
    logic [1:0] aluop_w [NI];
    logic [1:0] npcop_w [NI];
    logic       bsel_w [NI];
    logic [1:0] a3sel_w [NI];
    logic [1:0] wdsel_w [NI];
    logic       retire_w [NI];
    logic       err_w [NI];
    logic [16:0] obs [NI];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: MEM_LAT=0 halt, 1: MEM_LAT=2 halt, 2: MEM_LAT=1 refetch on trap
    function automatic int lat_of(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic bit halt_of(input int i);
        return i != 2;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            mc_ctrl #(
                .MEM_LAT  (gi == 1 ? 2 : (gi == 2 ? 1 : 0)),
                .TRAP_HALT(gi != 2)
            ) u_dut (
                .clk   (clk),
                .rst   (rst),
                .Op    (Op),
                .Funct (Funct),
                .Zero  (Zero),
                .PCWr  (pcwr_w[gi]),
                .IRWr  (irwr_w[gi]),
                .RFWr  (rfwr_w[gi]),
                .DMWr  (dmwr_w[gi]),
                .EXTOp (extop_w[gi]),
                .ALUOp (aluop_w[gi]),
                .NPCOp (npcop_w[gi]),
                .BSel  (bsel_w[gi]),
                .A3Sel (a3sel_w[gi]),
                .WDSel (wdsel_w[gi]),
                .retire(retire_w[gi]),
                .err   (err_w[gi])
            );
            assign obs[gi] = {pcwr_w[gi], irwr_w[gi], rfwr_w[gi], dmwr_w[gi], extop_w[gi],
                              aluop_w[gi], npcop_w[gi], bsel_w[gi], a3sel_w[gi], wdsel_w[gi],
                              retire_w[gi], err_w[gi]};
        end
    endgenerate

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    // Expected outputs t cycles after reset release while one instruction repeats.
    // Each instruction is a fixed sequence of phases whose lengths follow the CPI table.
    function automatic logic [16:0] model(input int lat, input bit halt, input logic [5:0] op,
                                          input logic [5:0] fn, input logic z, input int t);
        int c, len, p, q, k;
        logic pcwr, irwr, rfwr, dmwr, bsel, ret, er;
        logic [1:0] ext, alu, npc, a3, wd;
        c = lat + 1;
        {pcwr, irwr, rfwr, dmwr, bsel, ret, er} = 7'd0;
        {ext, alu, npc, a3, wd} = 10'd0;
        case (op)
            6'b000000: k = (fn == 6'b100001) ? 0 : ((fn == 6'b100011) ? 1 : 9);
            6'b001101: k = 2;
            6'b001111: k = 3;
            6'b100011: k = 4;
            6'b101011: k = 5;
            6'b000100: k = 6;
            6'b000010: k = 7;
            6'b000011: k = 8;
            default:   k = 9;
        endcase
        if (k <= 3)      len = c + 3;
        else if (k == 4) len = 2 * c + 3;
        else if (k == 5) len = 2 * c + 2;
        else             len = c + 2;
        if (k == 9 && halt) p = (t < c + 1) ? t : c + 1;
        else                p = t % len;
        q = p - c - 1;
        if (p < c) begin
            if (p == c - 1) begin
                pcwr = 1'b1;
                irwr = 1'b1;
            end
        end else if (p > c) begin
            case (k)
                0, 1, 2, 3: begin
                    alu  = (k == 1) ? 2'd1 : ((k >= 2) ? 2'd2 : 2'd0);
                    bsel = (k >= 2);
                    ext  = (k == 3) ? 2'd2 : 2'd0;
                    if (q == 1) begin
                        rfwr = 1'b1;
                        a3   = (k <= 1) ? 2'd1 : 2'd0;
                        ret  = 1'b1;
                    end
                end
                4, 5: begin
                    if (q == 0) begin
                        bsel = 1'b1;
                        ext  = 2'd1;
                    end else if (k == 4 && q == c + 1) begin
                        rfwr = 1'b1;
                        wd   = 2'd1;
                        ret  = 1'b1;
                    end else if (k == 5 && q == c) begin
                        dmwr = 1'b1;
                        ret  = 1'b1;
                    end
                end
                6: begin
                    alu  = 2'd1;
                    ext  = 2'd1;
                    npc  = 2'd1;
                    pcwr = z;
                    ret  = 1'b1;
                end
                7, 8: begin
                    npc  = 2'd2;
                    pcwr = 1'b1;
                    ret  = 1'b1;
                    if (k == 8) begin
                        rfwr = 1'b1;
                        a3   = 2'd2;
                        wd   = 2'd2;
                    end
                end
                default: er = 1'b1;
            endcase
        end
        return {pcwr, irwr, rfwr, dmwr, ext, alu, npc, bsel, a3, wd, ret, er};
    endfunction

    // Reset, hold one instruction on Op/Funct, then check ncyc cycles; optionally
    // pull reset asynchronously at the end and check every output drops at once.
    task automatic run_ep(input logic [5:0] op, input logic [5:0] fn, input logic z,
                          input int ncyc, input bit abort);
        rst   = 1'b0;
        Op    = op;
        Funct = fn;
        Zero  = z;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("rst_i%0d", i), obs[i], 17'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < ncyc; t++) begin
            #1;
            for (int i = 0; i < NI; i++)
                chk($sformatf("op%02h_fn%02h_z%0d_i%0d_t%0d", op, fn, z, i, t), obs[i],
                    model(lat_of(i), halt_of(i), op, fn, z, t));
            @(negedge clk);
        end
        if (abort) begin
            #2;
            rst = 1'b0;
            #1;
            for (int i = 0; i < NI; i++) chk($sformatf("async_rst_i%0d", i), obs[i], 17'd0);
        end
        $display("ep op=%b funct=%b zero=%0d cycles=%0d abort=%0d total=%0d bad=%0d",
                 op, fn, z, ncyc, abort, total, bad);
    endtask

    logic [5:0] legal_op [9];
    logic [5:0] legal_fn [9];

    initial begin
        logic [5:0] op, fn;
        int r;
        legal_op = '{6'b000000, 6'b000000, 6'b001101, 6'b001111, 6'b100011,
                     6'b101011, 6'b000100, 6'b000010, 6'b000011};
        legal_fn = '{6'b100001, 6'b100011, 6'b000000, 6'b000000, 6'b000000,
                     6'b000000, 6'b000000, 6'b000000, 6'b000000};
        rst   = 1'b0;
        Op    = 6'd0;
        Funct = 6'd0;
        Zero  = 1'b0;

        run_ep(6'b000000, 6'b100001, 1'b0, 24, 1'b0); // addu
        run_ep(6'b100011, 6'b000000, 1'b0, 24, 1'b0); // lw
        run_ep(6'b101011, 6'b000000, 1'b0, 24, 1'b0); // sw
        run_ep(6'b000100, 6'b000000, 1'b1, 24, 1'b0); // beq taken
        run_ep(6'b000100, 6'b000000, 1'b0, 24, 1'b0); // beq not taken
        run_ep(6'b000011, 6'b000000, 1'b0, 24, 1'b0); // jal
        run_ep(6'b111111, 6'b000000, 1'b0, 26, 1'b0); // illegal op
        run_ep(6'b000000, 6'b101010, 1'b0, 20, 1'b0); // illegal funct
        run_ep(6'b100011, 6'b000000, 1'b0, 6, 1'b1);  // reset mid-MEMRD
        run_ep(6'b001111, 6'b000000, 1'b0, 20, 1'b0); // lui after abort

        for (int e = 0; e < 40; e++) begin
            r = int'($urandom_range(0, 11));
            if (r < 9) begin
                op = legal_op[r];
                fn = (r < 2) ? legal_fn[r] : 6'($urandom);
            end else if (r == 9) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else if (r == 10) begin
                op = 6'b000000;
                fn = 6'($urandom);
            end else begin
                op = 6'b111111;
                fn = 6'($urandom);
            end
            run_ep(op, fn, 1'($urandom), int'($urandom_range(8, 30)), 1'($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
